// File: rtl/matrix_mult_stream_if.sv
// Stream bundle for matrix_mult_stream: element intake from the data generator
// and the row-major result stream towards the sink.
interface matrix_mult_stream_if #(
  parameter int N_BITS   = 8,
  parameter int DIM      = 4,
  parameter int ACC_BITS = 18
);
  localparam int RC_W = $clog2(DIM);

  // Intake: data_request releases one DIM*DIM burst, din is taken on every
  // din_valid beat, with no backpressure.
  // Result: c_valid/c_out/c_row/c_col stay stable until c_valid & c_ready are
  // both high at a rising edge; that edge transfers exactly one element.
  logic                data_request;
  logic [N_BITS-1:0]   din;
  logic                din_valid;
  logic [ACC_BITS-1:0] c_out;
  logic [RC_W-1:0]     c_row;
  logic [RC_W-1:0]     c_col;
  logic                c_valid;
  logic                c_ready;

  modport master (
    output data_request, c_out, c_row, c_col, c_valid,
    input  din, din_valid, c_ready
  );

  modport slave (
    input  data_request, c_out, c_row, c_col, c_valid,
    output din, din_valid, c_ready
  );
endinterface

// File: rtl/matrix_mult_stream.sv
// Loads two DIM x DIM signed matrices from a byte stream and emits C = A*B row-major,
// one sequential multiply-accumulate per cycle.
module matrix_mult_stream #(
  parameter int N_BITS   = 8,
  parameter int DIM      = 4,
  parameter int ACC_BITS = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  matrix_mult_stream_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic [2:0]          fsm_state
);
  // DIM is a power of two, so {row, col} concatenation is the row-major index.
  localparam int RC_W  = $clog2(DIM);
  localparam int IDX_W = 2 * RC_W;
  localparam int P_W   = 2 * N_BITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM * DIM - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_A, S_LOAD_A, S_REQ_B, S_LOAD_B, S_MAC, S_EMIT, S_FIN
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]         cnt;
  logic [RC_W-1:0]          i, j, k;
  logic [ACC_BITS-1:0]      acc;
  logic signed [N_BITS-1:0] a_mem [DIM*DIM];
  logic signed [N_BITS-1:0] b_mem [DIM*DIM];
  logic signed [N_BITS-1:0] a_el, b_el;
  logic signed [P_W-1:0]    prod;
  logic [ACC_BITS-1:0]      prod_ext;
  logic                     loading;

  assign loading  = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign a_el     = a_mem[{i, k}];
  assign b_el     = b_mem[{k, j}];
  assign prod     = a_el * b_el;
  assign prod_ext = {{(ACC_BITS-P_W){prod[P_W-1]}}, prod};

  assign bus.data_request = (state == S_REQ_A) || (state == S_REQ_B);
  assign bus.c_valid      = (state == S_EMIT);
  assign bus.c_out        = acc;
  assign bus.c_row        = i;
  assign bus.c_col        = j;
  assign busy             = (state != S_IDLE);
  assign done             = (state == S_FIN);
  assign fsm_state        = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_REQ_A;
      S_REQ_A:  state_next = S_LOAD_A;
      S_LOAD_A: if (bus.din_valid && cnt == IDX_LAST) state_next = S_REQ_B;
      S_REQ_B:  state_next = S_LOAD_B;
      S_LOAD_B: if (bus.din_valid && cnt == IDX_LAST) state_next = S_MAC;
      S_MAC:    if (k == RC_LAST) state_next = S_EMIT;
      S_EMIT: begin
        if (bus.c_ready) begin
          if (i == RC_LAST && j == RC_LAST) state_next = S_FIN;
          else                              state_next = S_MAC;
        end
      end
      S_FIN:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Counters and accumulator; i/j/k wrap back to zero naturally after the last element.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      acc     <= '0;
      overrun <= 1'b0;
    end else begin
      if (bus.din_valid && !loading) overrun <= 1'b1;
      case (state)
        S_REQ_A, S_REQ_B: cnt <= '0;
        S_LOAD_A, S_LOAD_B: begin
          if (bus.din_valid) cnt <= cnt + 1'b1;
        end
        S_MAC: begin
          k   <= k + 1'b1;
          acc <= ((k == '0) ? '0 : acc) + prod_ext;
        end
        S_EMIT: begin
          if (bus.c_ready) begin
            j <= j + 1'b1;
            if (j == RC_LAST) i <= i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD_A && bus.din_valid) a_mem[cnt] <= bus.din;
    if (state == S_LOAD_B && bus.din_valid) b_mem[cnt] <= bus.din;
  end
endmodule

// File: tb/tb_matrix_mult_stream.sv
// Directed bench for matrix_mult_stream: hand-computed C matrices queued per run and
// checked element by element at the result handshake.
module tb_matrix_mult_stream;
  localparam int N_BITS   = 8;
  localparam int DIM      = 4;
  localparam int ACC_BITS = 18;
  localparam int NEL      = DIM * DIM;
  localparam int EW       = ACC_BITS + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, overrun;
  logic [2:0] fsm_state;

  matrix_mult_stream_if #(.N_BITS(N_BITS), .DIM(DIM), .ACC_BITS(ACC_BITS)) bus ();

  matrix_mult_stream #(.N_BITS(N_BITS), .DIM(DIM), .ACC_BITS(ACC_BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int elem_cnt = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  int prev_hs = -1;
  bit chk_rate = 1'b0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.data_request) req_cnt++;
      if (done) done_cnt++;
      if (bus.c_valid && bus.c_ready) begin
        elem_cnt++;
        if (exp_q.size() == 0) begin
          check("c_extra", {10'd0, bus.c_row, bus.c_col, bus.c_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("c_elem", {bus.c_row, bus.c_col, bus.c_out}, e);
        end
        if (chk_rate && prev_hs >= 0) check("c_rate", cyc - prev_hs, DIM + 1);
        prev_hs = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_req(input string tag, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.data_request) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  task automatic feed(input logic [N_BITS-1:0] m[NEL], input int n_beats,
                      input int max_gap, input int start_beat);
    @(posedge clk); #1;
    for (int b = 0; b < n_beats; b++) begin
      bus.din       = m[b];
      bus.din_valid = 1'b1;
      start         = (b == start_beat);
      @(posedge clk); #1;
      bus.din_valid = 1'b0;
      start         = 1'b0;
      if (max_gap > 0 && b != n_beats - 1) begin
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic clear_counts();
    elem_cnt = 0;
    done_cnt = 0;
    req_cnt  = 0;
    prev_hs  = -1;
  endtask

  task automatic push_exp(input logic [ACC_BITS-1:0] c[NEL]);
    for (int x = 0; x < NEL; x++) begin
      logic [3:0] idx;
      idx = 4'(x);
      exp_q.push_back({idx[3:2], idx[1:0], c[x]});
    end
  endtask

  task automatic run(input logic [N_BITS-1:0] a[NEL], input logic [N_BITS-1:0] b[NEL],
                     input logic [ACC_BITS-1:0] c[NEL], input int max_gap, input int start_beat);
    bit ok;
    clear_counts();
    push_exp(c);
    pulse_start();
    wait_req("req_a", ok);
    if (ok) feed(a, NEL, max_gap, -1);
    wait_req("req_b", ok);
    if (ok) feed(b, NEL, max_gap, start_beat);
  endtask

  task automatic finish_run(input string tag);
    bit idle = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    check({tag, "_idle"}, idle, 1);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_elems"}, elem_cnt, NEL);
    check({tag, "_q_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  logic [N_BITS-1:0]   m_ident[NEL], m_two[NEL], m_seq[NEL], m_neg[NEL], m_ones[NEL], m_ramp[NEL];
  logic [ACC_BITS-1:0] c_seq[NEL], c_dbl[NEL], c_big[NEL], c_m2[NEL];

  initial begin
    bit ok;
    for (int x = 0; x < NEL; x++) begin
      m_ident[x] = (x / DIM == x % DIM) ? 8'd1 : 8'd0;
      m_two[x]   = (x / DIM == x % DIM) ? 8'd2 : 8'd0;
      m_seq[x]   = 8'(x + 1);
      m_neg[x]   = 8'h80;
      m_ones[x]  = 8'd1;
      m_ramp[x]  = 8'(x / DIM - 2);
      c_seq[x]   = 18'(x + 1);
      c_dbl[x]   = 18'(2 * (x + 1));
      c_big[x]   = 18'h10000;
      c_m2[x]    = 18'h3FFFE;
    end
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.c_ready   = 1'b1;

    // Reset, with start held during reset: reset wins.
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("rst_state", fsm_state, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_req", bus.data_request, 0);
    check("rst_c_valid", bus.c_valid, 0);
    check("rst_c_out", {bus.c_row, bus.c_col, bus.c_out}, 0);

    // 1: identity * sequence, with latency and throughput checks.
    @(posedge clk); #1;
    chk_rate = 1'b1;
    run(m_ident, m_seq, c_seq, 0, -1);
    begin
      int lat = 0;
      for (int t = 1; t <= 50; t++) begin
        @(negedge clk);
        if (bus.c_valid) begin
          lat = t;
          break;
        end
      end
      check("latency", lat, DIM + 1);
    end
    finish_run("t1");
    chk_rate = 1'b0;
    check("t1_req_cnt", req_cnt, 2);

    // 2: most negative operands, largest magnitude result.
    @(posedge clk); #1;
    run(m_neg, m_neg, c_big, 0, -1);
    finish_run("t2");

    // 3: signed B rows -2..1 against all-ones A.
    @(posedge clk); #1;
    run(m_ones, m_ramp, c_m2, 0, -1);
    finish_run("t3");

    // 4: result sink stalls for 10 cycles on the first element.
    @(posedge clk); #1;
    bus.c_ready = 1'b0;
    run(m_two, m_seq, c_dbl, 0, -1);
    begin
      bit seen = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (bus.c_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("stall_seen", seen, 1);
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        check("stall_valid", bus.c_valid, 1);
        if (exp_q.size() > 0) check("stall_elem", {bus.c_row, bus.c_col, bus.c_out}, exp_q[0]);
      end
    end
    @(posedge clk); #1;
    bus.c_ready = 1'b1;
    finish_run("t4");

    // 5: gaps between beats, stray start during LOAD_B.
    @(posedge clk); #1;
    run(m_ident, m_seq, c_seq, 3, 3);
    finish_run("t5");
    check("t5_req_cnt", req_cnt, 2);

    // 7: din_valid in IDLE sets a sticky overrun.
    @(posedge clk); #1;
    bus.din_valid = 1'b1;
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    @(negedge clk);
    check("ovr_set", overrun, 1);
    @(posedge clk); #1;
    run(m_ones, m_ramp, c_m2, 0, -1);
    finish_run("t7");
    check("ovr_sticky", overrun, 1);

    // 6: reset mid LOAD_B aborts; a fresh run then works.
    @(posedge clk); #1;
    clear_counts();
    pulse_start();
    wait_req("t6_req_a", ok);
    if (ok) feed(m_two, NEL, 0, -1);
    wait_req("t6_req_b", ok);
    if (ok) feed(m_seq, 5, 0, -1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_state", fsm_state, 0);
    check("t6_busy", busy, 0);
    check("t6_overrun", overrun, 0);
    check("t6_c_valid", bus.c_valid, 0);
    check("t6_req", bus.data_request, 0);
    check("t6_c_out", {bus.c_row, bus.c_col, bus.c_out}, 0);
    repeat (10) @(negedge clk);
    check("t6_no_elems", elem_cnt, 0);
    @(posedge clk); #1;
    run(m_two, m_seq, c_dbl, 1, -1);
    finish_run("t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
